// File: rtl/alu_cmd_sequencer.sv
// Command FIFO in front of the 8-bit combinational ALU. The head entry drives
// the ALU inputs; each pop captures the ALU result into an output register
// that is handed downstream over a valid/ready handshake.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [2:0]       alu_s,
  input  logic [8:0]       alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [8:0]       res_data,
  output logic [2:0]       res_op,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             push;
  logic             pop;

  // Ready and pop both look only at the registered count, so a full FIFO
  // cannot accept in the same cycle it frees a slot, and an empty FIFO
  // cannot pop the command arriving in the same cycle.
  assign empty     = (fifo_count == '0);
  assign cmd_ready = (fifo_count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = !empty && (!res_valid || res_ready);

  assign head  = mem[rd_ptr];
  assign alu_a = empty ? 8'h00 : head.a;
  assign alu_b = empty ? 8'h00 : head.b;
  assign alu_s = empty ? 3'b000 : head.op;

  // Command storage; contents need no reset because the count gates their use.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Result register: capture the full 9-bit ALU result on pop, release on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= '0;
    end else if (pop) begin
      res_valid <= 1'b1;
      res_data  <= alu_out;
      res_op    <= head.op;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural ALU closing the loop.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_s;
  logic [8:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [8:0] res_data;
  logic [2:0] res_op;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int n_res = 0;
  logic last_acc;
  logic [11:0] sb [$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [8:0] exp;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .fifo_count(fifo_count)
  );

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    logic [15:0] prod;
    prod = 16'(a) * 16'(b);
    case (s)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return prod[8:0];
      3'd6:    return {a, 1'b0};
      default: return {1'b0, a};
    endcase
  endfunction

  // Behavioural ALU driven by the sequencer's head-entry outputs.
  always_comb alu_out = alu_f(alu_a, alu_b, alu_s);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: score the handshakes about to happen, then advance to the next falling edge.
  task automatic tick();
    logic hs_cmd, hs_res;
    logic [11:0] e;
    hs_cmd = !rst && cmd_valid && cmd_ready;
    hs_res = !rst && res_valid && res_ready;
    last_acc = hs_cmd;
    if (hs_res) begin
      n_res++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %0h expected none", res_data);
      end else begin
        e = sb.pop_front();
        check("sb_data", res_data, e[8:0]);
        check("sb_op", res_op, e[11:9]);
      end
    end
    if (hs_cmd) sb.push_back({cmd_op, alu_f(cmd_a, cmd_b, cmd_op)});
    if (rst) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
  endtask

  task automatic drain(input string name);
    logic done;
    done = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 30 && !done; c++) begin
      if (!res_valid && fifo_count == 0) done = 1'b1;
      else tick();
    end
    check(name, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0, acc_cnt, sent, cyc;
    logic acc5;

    vecs[0] = '{8'hFF, 8'h01, 3'd0, 9'h100};
    vecs[1] = '{8'h10, 8'h20, 3'd1, 9'h1F0};
    vecs[2] = '{8'hF0, 8'h3C, 3'd2, 9'h030};
    vecs[3] = '{8'hF0, 8'h0F, 3'd3, 9'h0FF};
    vecs[4] = '{8'hAA, 8'hFF, 3'd4, 9'h055};
    vecs[5] = '{8'h13, 8'h11, 3'd5, 9'h143};
    vecs[6] = '{8'h81, 8'h00, 3'd6, 9'h102};
    vecs[7] = '{8'h7E, 8'h00, 3'd7, 9'h07E};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_op", res_op, 0);
    check("rst_count", fifo_count, 0);
    check("rst_alu", {alu_a, alu_b, alu_s}, 0);
    rst = 1'b0;

    // Single command: result one edge after acceptance.
    res_ready = 1'b1;
    drive(8'h05, 8'h03, 3'd0);
    tick();
    check("single_acc", last_acc, 1);
    check("single_count", fifo_count, 1);
    check("single_alu", {alu_a, alu_b, alu_s}, {8'h05, 8'h03, 3'd0});
    check("single_early_valid", res_valid, 0);
    cmd_valid = 1'b0;
    tick();
    check("single_valid", res_valid, 1);
    check("single_data", res_data, 9'h008);
    check("single_op", res_op, 0);
    check("single_empty_alu", {alu_a, alu_b, alu_s}, 0);
    tick();
    check("single_release", res_valid, 0);
    check("single_hold_data", res_data, 9'h008);

    // Back-to-back stream through all opcodes.
    n0 = n_res;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) check("stream_ready", cmd_ready, 1);
      if (i >= 1 && i <= 8) check("stream_alu_a", alu_a, vecs[i-1].a);
      if (i >= 2) begin
        check("stream_valid", res_valid, 1);
        check("stream_data", res_data, vecs[i-2].exp);
        check("stream_op", res_op, vecs[i-2].op);
      end
      if (i < 8) drive(vecs[i].a, vecs[i].b, vecs[i].op);
      else cmd_valid = 1'b0;
      tick();
    end
    check("stream_results", n_res - n0, 8);
    check("stream_idle", res_valid, 0);

    // Output stall fills the FIFO.
    res_ready = 1'b0;
    acc_cnt = 0;
    acc5 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(8'h10 + 8'(k), 8'h03, 3'(k));
      tick();
      if (last_acc) acc_cnt++;
      if (k == 5) acc5 = last_acc;
    end
    check("stall_accepted", acc_cnt, 5);
    check("stall_refused", acc5, 0);
    check("stall_count", fifo_count, 4);
    check("stall_ready", cmd_ready, 0);
    check("stall_valid", res_valid, 1);
    check("stall_data", res_data, 9'h013);
    check("stall_head", alu_a, 8'h11);
    cmd_valid = 1'b0;
    tick();
    check("stall_hold_data", res_data, 9'h013);
    check("stall_hold_count", fifo_count, 4);
    n0 = n_res;
    drain("stall_drain");
    check("stall_drained", n_res - n0, 5);
    check("stall_ready_back", cmd_ready, 1);

    // Full with simultaneous pop: push refused, accepted next cycle.
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(8'h20 + 8'(k), 8'h0F, 3'd3);
      tick();
    end
    check("full_count", fifo_count, 4);
    res_ready = 1'b1;
    drive(8'hC3, 8'h3C, 3'd4);
    check("fullpop_ready", cmd_ready, 0);
    tick();
    check("fullpop_refused", last_acc, 0);
    check("fullpop_count", fifo_count, 3);
    check("fullpop_ready_after", cmd_ready, 1);
    res_ready = 1'b0;
    tick();
    check("fullpop_retry_acc", last_acc, 1);
    check("fullpop_refill", fifo_count, 4);
    n0 = n_res;
    drain("fullpop_drain");
    check("fullpop_drained", n_res - n0, 5);

    // Wrap-around with random backpressure.
    n0 = n_res;
    sent = 0;
    cyc = 0;
    while (sent < 13 && cyc < 400) begin
      drive(8'($urandom), 8'($urandom), 3'($urandom));
      res_ready = 1'($urandom_range(0, 1));
      tick();
      if (last_acc) sent++;
      cyc++;
    end
    check("wrap_sent", sent, 13);
    drain("wrap_drain");
    check("wrap_results", n_res - n0, 13);
    check("wrap_sb_empty", sb.size(), 0);

    // Reset mid-burst.
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(8'h50 + 8'(k), 8'h02, 3'd6);
      tick();
    end
    check("midrst_pre_count", fifo_count, 3);
    check("midrst_pre_valid", res_valid, 1);
    rst = 1'b1;
    res_ready = 1'b1;
    drive(8'h77, 8'h77, 3'd0);
    tick();
    check("midrst_valid", res_valid, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_alu", {alu_a, alu_b, alu_s}, 0);
    check("midrst_data", res_data, 0);
    check("midrst_op", res_op, 0);
    rst = 1'b0;
    cmd_valid = 1'b0;
    acc_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (res_valid) acc_cnt++;
    end
    check("midrst_no_stale", acc_cnt, 0);
    drive(8'h40, 8'h40, 3'd0);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("midrst_after_valid", res_valid, 1);
    check("midrst_after_data", res_data, 9'h080);
    drain("midrst_drain");
    check("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
